// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM-port arbiter: default address/data widths,
// the request record carried from the winning requester to the RAM port,
// and a wrap-around index helper.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_WORD_W = 64;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_WORD_W-1:0] wdata;
  } mem_req_t;

  // Next index in a ring of n entries, wrapping n-1 back to 0.
  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle of the RAM-port arbiter: per-requester request
// lanes plus the shared response strobe/data. The arbiter uses the slave
// modport; the requesters (or a bench) drive the master side.
interface mem_port_arbiter_if
  import mem_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned WORD_W  = MEM_WORD_W
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][WORD_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [WORD_W-1:0]              rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Rotating-priority picker: scans the request vector starting at index
// base, wrapping past NUM_REQ-1, and returns a one-hot grant for the first
// asserted request (all zero when nothing is requested).
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   base,
  output logic [NUM_REQ-1:0] grant
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  // First requester at or after base (modulo NUM_REQ) wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, base} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM among NUM_REQ requesters. One access per
// cycle is granted combinationally and forwarded to the RAM; the response
// (read data, or the written data as a write acknowledge) is strobed back
// to the granted requester exactly one cycle later.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// left undefined the arbiter is fixed priority (lowest index wins) and the
// rotation pointer is not built.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned WORD_W  = MEM_WORD_W
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   port,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [WORD_W-1:0]   ram_data,
  output logic                ram_wren,
  input  logic [WORD_W-1:0]   ram_q
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   base;
  logic [NUM_REQ-1:0] arb_grant;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic [IDX_W-1:0]   grant_id;
  mem_req_t           sel_req;
  logic               rsp_pending;
  logic [IDX_W-1:0]   rsp_id;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;

  // Rotate the search start to just past the last winner; idle cycles hold it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= IDX_W'(wrap_inc(32'(grant_id), NUM_REQ));
    end
  end

  assign base = ptr;
`else
  assign base = '0;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req   (port.req_valid),
    .base  (base),
    .grant (arb_grant)
  );

  assign grant          = reset ? '0 : arb_grant;
  assign any_grant      = |grant;
  assign port.req_ready = grant;

  // Encode the winner and route its request to the RAM port; zeros when idle.
  always_comb begin
    grant_id = '0;
    sel_req  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id      = IDX_W'(i);
        sel_req.we    = port.req_we[i];
        sel_req.addr  = MEM_ADDR_W'(port.req_addr[i]);
        sel_req.wdata = MEM_WORD_W'(port.req_wdata[i]);
      end
    end
  end

  assign ram_address = ADDR_W'(sel_req.addr);
  assign ram_data    = WORD_W'(sel_req.wdata);
  assign ram_wren    = sel_req.we;

  // Remember who was granted so the RAM's registered output can be returned.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_pending <= 1'b0;
      rsp_id      <= '0;
    end else begin
      rsp_pending <= any_grant;
      if (any_grant) rsp_id <= grant_id;
    end
  end

  // Reset also masks a response already pending, so an access granted just
  // before reset never produces a strobe.
  always_comb begin
    port.rsp_valid = '0;
    if (rsp_pending && !reset) port.rsp_valid[rsp_id] = 1'b1;
  end

  assign port.rsp_rdata = ram_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a directed vector table covering reset,
// single read, write-then-read, saturated arbitration, reset during an
// outstanding grant and idle cycles, followed by randomized traffic checked
// against a transaction-level model (policy scan + shadow memory).
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned WW = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .WORD_W(WW)) bus ();

  logic [AW-1:0] ram_address;
  logic [WW-1:0] ram_data;
  logic          ram_wren;
  logic [WW-1:0] ram_q;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .WORD_W(WW)) dut (
    .clk         (clk),
    .reset       (reset),
    .port        (bus.slave),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  // RAM: 32 words, registered output, write returns the written data.
  logic [WW-1:0] mem [32];
  logic          reinit;

  function automatic logic [63:0] init_word(int i);
    return (i == 16) ? 64'hDEAD : 64'hA000 + 64'(i);
  endfunction

  always @(posedge clk) begin
    if (reinit) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else if (ram_wren) begin
      mem[ram_address[4:0]] <= ram_data;
      ram_q <= ram_data;
    end else begin
      ram_q <= mem[ram_address[4:0]];
    end
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic            rst;
    logic [3:0]      valid;
    logic [3:0]      we;
    logic [3:0][31:0] addr;
    logic [3:0][63:0] wdata;
    logic [3:0]      e_ready;
    logic            e_wren;
    logic [31:0]     e_addr;
    logic [63:0]     e_data;
    logic [3:0]      e_rsp;
    logic [63:0]     e_rdata;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic [3:0] valid, logic [3:0] we,
                              logic [3:0][31:0] addr, logic [3:0][63:0] wdata,
                              logic [3:0] e_ready, logic e_wren, logic [31:0] e_addr,
                              logic [63:0] e_data, logic [3:0] e_rsp, logic [63:0] e_rdata);
    vec_t v;
    v.rst = rst; v.valid = valid; v.we = we; v.addr = addr; v.wdata = wdata;
    v.e_ready = e_ready; v.e_wren = e_wren; v.e_addr = e_addr; v.e_data = e_data;
    v.e_rsp = e_rsp; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic drive(logic rst, logic [3:0] valid, logic [3:0] we,
                       logic [3:0][31:0] addr, logic [3:0][63:0] wdata);
    reset         = rst;
    bus.req_valid = valid;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  // Reference model state (random phase).
  logic [63:0] shadow [32];
  int          m_ptr;
  bit          m_pend;
  int          m_pid;
  logic [63:0] m_pdata;

  initial begin
    logic [3:0][31:0] a0, a_rd, a_wr, a_r1, a_mix, a_all, r_addr;
    logic [3:0][63:0] w0, w55, r_wdata;
    logic [3:0] r_valid, r_we, e_rsp;
    logic r_rst;
    int g, ai;

    a0    = '0;
    a_rd  = {32'h0, 32'h0, 32'h0, 32'h10};
    a_wr  = {32'h0, 32'h4, 32'h0, 32'h0};
    a_r1  = {32'h0, 32'h0, 32'h8, 32'h0};
    a_mix = {32'h3, 32'h2, 32'h8, 32'h0};
    a_all = {32'h23, 32'h22, 32'h21, 32'h20};
    w0    = '0;
    w55   = {64'h0, 64'h55, 64'h0, 64'h0};

    //         rst valid    we       addr   wdata  ready    wren addr    data   rsp      rdata
    vt.push_back(mk(1, 4'b0001, 4'b0000, a_rd,  w0,  4'b0000, 0, 32'h0,  64'h0,  4'b0000, 64'h0));
    vt.push_back(mk(1, 4'b0000, 4'b0000, a0,    w0,  4'b0000, 0, 32'h0,  64'h0,  4'b0000, 64'h0));
    vt.push_back(mk(0, 4'b0001, 4'b0000, a_rd,  w0,  4'b0001, 0, 32'h10, 64'h0,  4'b0000, 64'h0));
    vt.push_back(mk(0, 4'b0000, 4'b0000, a0,    w0,  4'b0000, 0, 32'h0,  64'h0,  4'b0001, 64'hDEAD));
    vt.push_back(mk(0, 4'b0100, 4'b0100, a_wr,  w55, 4'b0100, 1, 32'h4,  64'h55, 4'b0000, 64'h0));
    vt.push_back(mk(0, 4'b0100, 4'b0000, a_wr,  w55, 4'b0100, 0, 32'h4,  64'h55, 4'b0100, 64'h55));
    vt.push_back(mk(0, 4'b0000, 4'b0000, a0,    w0,  4'b0000, 0, 32'h0,  64'h0,  4'b0100, 64'h55));
    vt.push_back(mk(0, 4'b0000, 4'b0000, a0,    w0,  4'b0000, 0, 32'h0,  64'h0,  4'b0000, 64'h0));
    vt.push_back(mk(0, 4'b0010, 4'b0000, a_r1,  w0,  4'b0010, 0, 32'h8,  64'h0,  4'b0000, 64'h0));
    vt.push_back(mk(1, 4'b0000, 4'b0000, a0,    w0,  4'b0000, 0, 32'h0,  64'h0,  4'b0000, 64'h0));
    vt.push_back(mk(0, 4'b1110, 4'b0000, a_mix, w0,  4'b0010, 0, 32'h8,  64'h0,  4'b0000, 64'h0));
    vt.push_back(mk(1, 4'b0000, 4'b0000, a0,    w0,  4'b0000, 0, 32'h0,  64'h0,  4'b0000, 64'h0));
`ifdef MEM_ARB_ROUND_ROBIN_EN
    vt.push_back(mk(0, 4'b1111, 4'b0000, a_all, w0,  4'b0001, 0, 32'h20, 64'h0,  4'b0000, 64'h0));
    vt.push_back(mk(0, 4'b1111, 4'b0000, a_all, w0,  4'b0010, 0, 32'h21, 64'h0,  4'b0001, 64'hA000));
    vt.push_back(mk(0, 4'b1111, 4'b0000, a_all, w0,  4'b0100, 0, 32'h22, 64'h0,  4'b0010, 64'hA001));
    vt.push_back(mk(0, 4'b1111, 4'b0000, a_all, w0,  4'b1000, 0, 32'h23, 64'h0,  4'b0100, 64'hA002));
    vt.push_back(mk(0, 4'b1111, 4'b0000, a_all, w0,  4'b0001, 0, 32'h20, 64'h0,  4'b1000, 64'hA003));
`else
    vt.push_back(mk(0, 4'b1111, 4'b0000, a_all, w0,  4'b0001, 0, 32'h20, 64'h0,  4'b0000, 64'h0));
    vt.push_back(mk(0, 4'b1111, 4'b0000, a_all, w0,  4'b0001, 0, 32'h20, 64'h0,  4'b0001, 64'hA000));
    vt.push_back(mk(0, 4'b1111, 4'b0000, a_all, w0,  4'b0001, 0, 32'h20, 64'h0,  4'b0001, 64'hA000));
    vt.push_back(mk(0, 4'b1111, 4'b0000, a_all, w0,  4'b0001, 0, 32'h20, 64'h0,  4'b0001, 64'hA000));
    vt.push_back(mk(0, 4'b1111, 4'b0000, a_all, w0,  4'b0001, 0, 32'h20, 64'h0,  4'b0001, 64'hA000));
`endif
    vt.push_back(mk(0, 4'b0000, 4'b0000, a0,    w0,  4'b0000, 0, 32'h0,  64'h0,  4'b0001, 64'hA000));
    vt.push_back(mk(0, 4'b0000, 4'b0000, a0,    w0,  4'b0000, 0, 32'h0,  64'h0,  4'b0000, 64'h0));

    // Load RAM contents while the DUT is held in reset.
    reinit = 1'b1;
    drive(1'b1, 4'b0000, 4'b0000, a0, w0);
    @(posedge clk);
    #1 reinit = 1'b0;

    // Directed table.
    for (int k = 0; k < vt.size(); k++) begin
      drive(vt[k].rst, vt[k].valid, vt[k].we, vt[k].addr, vt[k].wdata);
      @(negedge clk);
      check($sformatf("v%0d.ready", k), 64'(bus.req_ready), 64'(vt[k].e_ready));
      check($sformatf("v%0d.wren", k),  64'(ram_wren),      64'(vt[k].e_wren));
      check($sformatf("v%0d.addr", k),  64'(ram_address),   64'(vt[k].e_addr));
      check($sformatf("v%0d.data", k),  ram_data,           vt[k].e_data);
      check($sformatf("v%0d.rsp", k),   64'(bus.rsp_valid), 64'(vt[k].e_rsp));
      if (vt[k].e_rsp != 4'b0000)
        check($sformatf("v%0d.rdata", k), bus.rsp_rdata, vt[k].e_rdata);
      @(posedge clk);
      #1;
    end

    // Random phase: fresh RAM contents and a reset to align the model.
    reinit = 1'b1;
    drive(1'b1, 4'b0000, 4'b0000, a0, w0);
    @(posedge clk);
    #1 reinit = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = init_word(i);
    m_ptr = 0; m_pend = 0; m_pid = 0; m_pdata = '0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      r_rst   = ($urandom_range(0, 99) < 3);
      r_valid = 4'($urandom);
      r_we    = 4'($urandom);
      for (int j = 0; j < 4; j++) begin
        r_addr[j]  = 32'($urandom_range(0, 31));
        r_wdata[j] = {$urandom, $urandom};
      end
      drive(r_rst, r_valid, r_we, r_addr, r_wdata);

      // Winner: first valid requester scanning from the model pointer.
      g = -1;
      if (!r_rst)
        for (int k = 0; k < 4; k++)
          if (g < 0 && r_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;

      @(negedge clk);
      check($sformatf("r%0d.ready", cyc), 64'(bus.req_ready), (g < 0) ? 64'h0 : 64'(1) << g);
      check($sformatf("r%0d.wren", cyc),  64'(ram_wren),      (g < 0) ? 64'h0 : 64'(r_we[g]));
      check($sformatf("r%0d.addr", cyc),  64'(ram_address),   (g < 0) ? 64'h0 : 64'(r_addr[g]));
      check($sformatf("r%0d.data", cyc),  ram_data,           (g < 0) ? 64'h0 : r_wdata[g]);
      e_rsp = (m_pend && !r_rst) ? 4'(1 << m_pid) : 4'b0000;
      check($sformatf("r%0d.rsp", cyc),   64'(bus.rsp_valid), 64'(e_rsp));
      if (e_rsp != 4'b0000)
        check($sformatf("r%0d.rdata", cyc), bus.rsp_rdata, m_pdata);

      @(posedge clk);
      #1;
      if (r_rst) begin
        m_pend = 0;
        m_ptr  = 0;
      end else begin
        m_pend = (g >= 0);
        if (g >= 0) begin
          ai      = int'(r_addr[g]) % 32;
          m_pid   = g;
          m_pdata = r_we[g] ? r_wdata[g] : shadow[ai];
          if (r_we[g]) shadow[ai] = r_wdata[g];
`ifdef MEM_ARB_ROUND_ROBIN_EN
          m_ptr = (g + 1) % 4;
`endif
        end
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
